// File: rtl/aes_round_stepper_pkg.sv
// aes_round_stepper_pkg: key-size encodings, round-index width and the Nr lookup shared by the stepper.
package aes_round_stepper_pkg;
    typedef enum logic [1:0] {
        KEYSZ_128 = 2'd0,
        KEYSZ_192 = 2'd1,
        KEYSZ_256 = 2'd2
    } keysz_e;
    localparam int NR_BASE = 10;
    localparam int ROUND_W = 5;
    // The unused switch code 3 falls back to AES-128.
    function automatic logic [3:0] nr_of(input logic [1:0] size);
        return (size == 2'd3) ? 4'(NR_BASE) : 4'(NR_BASE + 2 * int'(size));
    endfunction
endpackage

// File: rtl/aes_round_stepper_if.sv
// aes_round_stepper_if: bundle of the button/switch inputs and the round-index outputs.
//   key_raw    raw active-low pushbutton       key_size  key-size switches
//   round      step index 0..2*Nr              dec_phase round > Nr
//   done       round == 2*Nr                   step_pulse one-cycle strobe per accepted step
//   nr         Nr of the active key size
interface aes_round_stepper_if;
    import aes_round_stepper_pkg::*;
    logic               key_raw;
    logic [1:0]         key_size;
    logic [ROUND_W-1:0] round;
    logic               dec_phase;
    logic               done;
    logic               step_pulse;
    logic [3:0]         nr;
    modport master (output key_raw, key_size, input round, dec_phase, done, step_pulse, nr);
    modport slave  (input key_raw, key_size, output round, dec_phase, done, step_pulse, nr);
endinterface

// File: rtl/aes_round_stepper_key_debounce.sv
// key_debounce: two-flop synchronizer, stability counter and one-cycle press strobe for an active-low button.
//   clk, rst_n  clock and asynchronous active-low reset
//   key_raw_i   raw button level (0 = pressed), asynchronous
//   press_o     one-cycle strobe on each debounced 1->0 transition
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw_i,
    output logic press_o
);
    logic             sync1_q, sync2_q, level_q, level_d, prev_q, press_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The counter only runs while the synchronized level disagrees with the accepted one,
    // so any agreeing cycle restarts the stability window.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) level_d = sync2_q;
            else cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            prev_q  <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= key_raw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            prev_q  <= level_q;
            press_q <= prev_q & ~level_q;
        end
    end

    assign press_o = press_q;
endmodule

// File: rtl/aes_round_stepper.sv
// aes_round_stepper: debounced, saturating, key-size-aware round index for the AES demo datapath.
//   clk, rst_n  clock and asynchronous active-low reset
//   bus         slave side of aes_round_stepper_if (key_raw/key_size in; round, dec_phase,
//               done, step_pulse, nr out)
module aes_round_stepper
    import aes_round_stepper_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    aes_round_stepper_if.slave    bus
);
    logic               press, size_chg, step_d, dec_q, done_q, step_q;
    logic [1:0]         ks_s1_q, ks_s2_q;
    keysz_e             size_q, size_d;
    logic [ROUND_W-1:0] round_q, round_d, lim;
    logic [3:0]         nr_q, nr_cur;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_raw_i (bus.key_raw),
        .press_o   (press)
    );

    // A size change restarts the sequence and swallows a coincident press.
    always_comb begin
        size_d   = (ks_s2_q == 2'd3) ? KEYSZ_128 : keysz_e'(ks_s2_q);
        size_chg = size_d != size_q;
        nr_cur   = nr_of(size_q);
        lim      = {nr_cur, 1'b0};
        step_d   = !size_chg && press && (round_q < lim);
        round_d  = size_chg ? '0 : step_d ? round_q + 1'b1 : round_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ks_s1_q <= 2'd0;
            ks_s2_q <= 2'd0;
            size_q  <= KEYSZ_128;
            round_q <= '0;
            step_q  <= 1'b0;
            nr_q    <= 4'(NR_BASE);
            dec_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            ks_s1_q <= bus.key_size;
            ks_s2_q <= ks_s1_q;
            size_q  <= size_d;
            round_q <= round_d;
            step_q  <= step_d;
            nr_q    <= nr_cur;
            dec_q   <= round_d > ROUND_W'(nr_cur);
            done_q  <= round_d == lim;
        end
    end

    assign bus.round      = round_q;
    assign bus.dec_phase  = dec_q;
    assign bus.done       = done_q;
    assign bus.step_pulse = step_q;
    assign bus.nr         = nr_q;
endmodule

// File: tb/tb_aes_round_stepper.sv
module tb_aes_round_stepper;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   pulses = 0;

    aes_round_stepper_if bus ();

    aes_round_stepper #(.DEBOUNCE_CYCLES(D), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bus.step_pulse === 1'b1) pulses++;

    typedef struct {
        logic [1:0] ks;
        int         presses;
        int         rnd;
        int         nr;
        int         dec;
        int         done;
        int         npulse;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input int lo, input int hi);
        bus.key_raw = 1'b0;
        tick(lo);
        bus.key_raw = 1'b1;
        tick(hi);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic check_all(input string tag, input int rnd, input int nr, input int dec, input int done);
        check({tag, ".round"}, 32'(bus.round), rnd);
        check({tag, ".nr"}, 32'(bus.nr), nr);
        check({tag, ".dec"}, 32'(bus.dec_phase), dec);
        check({tag, ".done"}, 32'(bus.done), done);
    endtask

    initial begin
        int size_m, round_m, nr_m, exp_p, r, ks, m;
        bus.key_raw  = 1'b1;
        bus.key_size = 2'd0;
        vecs[0] = '{2'd0, 5, 5, 10, 0, 0, 5};
        vecs[1] = '{2'd0, 10, 10, 10, 0, 0, 10};
        vecs[2] = '{2'd0, 11, 11, 10, 1, 0, 11};
        vecs[3] = '{2'd0, 20, 20, 10, 1, 1, 20};
        vecs[4] = '{2'd0, 21, 20, 10, 1, 1, 20};
        vecs[5] = '{2'd1, 13, 13, 12, 1, 0, 13};
        vecs[6] = '{2'd1, 26, 24, 12, 1, 1, 24};
        vecs[7] = '{2'd2, 14, 14, 14, 0, 0, 14};
        vecs[8] = '{2'd2, 28, 28, 14, 1, 1, 28};
        vecs[9] = '{2'd3, 3, 3, 10, 0, 0, 3};

        // reset state, during and after reset
        tick(3);
        check_all("rst_hold", 0, 10, 0, 0);
        check("rst_hold.step", 32'(bus.step_pulse), 0);
        rst_n = 1'b1;
        pulses = 0;
        tick(5);
        check_all("rst_rel", 0, 10, 0, 0);
        check("rst_rel.pulses", pulses, 0);

        // bounce rejection
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            bus.key_raw = 1'b0;
            tick(2);
            bus.key_raw = 1'b1;
            tick(2);
        end
        tick(10);
        check("bounce.round", 32'(bus.round), 0);
        check("bounce.pulses", pulses, 0);

        // press latency is D+4 edges from the key drop
        pulses = 0;
        bus.key_raw = 1'b0;
        tick(D + 3);
        check("lat.early", 32'(bus.round), 0);
        tick(1);
        check("lat.round", 32'(bus.round), 1);
        check("lat.step", 32'(bus.step_pulse), 1);
        tick(1);
        check("lat.step_end", 32'(bus.step_pulse), 0);
        tick(10);
        check("lat.held_pulses", pulses, 1);
        bus.key_raw = 1'b1;
        tick(10);

        // table of sizes/press counts
        for (int v = 0; v < 10; v++) begin
            do_reset();
            bus.key_size = vecs[v].ks;
            tick(5);
            pulses = 0;
            repeat (vecs[v].presses) press(10, 10);
            check_all($sformatf("vec%0d", v), vecs[v].rnd, vecs[v].nr, vecs[v].dec, vecs[v].done);
            check($sformatf("vec%0d.pulses", v), pulses, vecs[v].npulse);
        end

        // dec_phase rises together with round 11 under AES-128
        bus.key_size = 2'd0;
        do_reset();
        tick(3);
        repeat (10) press(10, 10);
        bus.key_raw = 1'b0;
        tick(D + 3);
        check("dec_edge.before", 32'({bus.round, bus.dec_phase}), 32'({5'd10, 1'b0}));
        tick(1);
        check("dec_edge.after", 32'({bus.round, bus.dec_phase}), 32'({5'd11, 1'b1}));
        bus.key_raw = 1'b1;
        tick(10);

        // size change lands on the same cycle as a debounced press
        do_reset();
        repeat (7) press(10, 10);
        check("szc.start", 32'(bus.round), 7);
        pulses = 0;
        bus.key_raw = 1'b0;
        tick(D + 1);
        bus.key_size = 2'd1;
        tick(2);
        check("szc.pre", 32'(bus.round), 7);
        tick(1);
        check("szc.round0", 32'(bus.round), 0);
        check("szc.nostep", 32'(bus.step_pulse), 0);
        tick(1);
        check("szc.nr", 32'(bus.nr), 12);
        bus.key_raw = 1'b1;
        tick(10);
        check("szc.pulses", pulses, 0);
        press(10, 10);
        check("szc.next", 32'(bus.round), 1);

        // asynchronous reset while the key is held low
        bus.key_size = 2'd0;
        do_reset();
        tick(3);
        repeat (5) press(10, 10);
        check("arst.start", 32'(bus.round), 5);
        bus.key_raw = 1'b0;
        tick(2);
        #2 rst_n = 1'b0;
        #1 check("arst.immediate", 32'(bus.round), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        pulses = 0;
        tick(D + 3);
        check("arst.early", 32'(bus.round), 0);
        tick(1);
        check("arst.step", 32'(bus.round), 1);
        bus.key_raw = 1'b1;
        tick(10);
        check("arst.pulses", pulses, 1);

        // randomized presses, glitches and size changes against a transaction model
        bus.key_size = 2'd0;
        do_reset();
        tick(3);
        size_m = 0;
        round_m = 0;
        for (int it = 0; it < 80; it++) begin
            r = $urandom_range(0, 9);
            pulses = 0;
            exp_p = 0;
            if (r < 7) begin
                press($urandom_range(D + 5, 12), $urandom_range(D + 5, 12));
                if (round_m < 2 * (10 + 2 * size_m)) begin
                    round_m++;
                    exp_p = 1;
                end
            end else if (r < 9) begin
                press($urandom_range(1, D - 1), 10);
            end else begin
                ks = $urandom_range(0, 3);
                bus.key_size = 2'(ks);
                tick(6);
                m = (ks == 3) ? 0 : ks;
                if (m != size_m) begin
                    size_m = m;
                    round_m = 0;
                end
            end
            nr_m = 10 + 2 * size_m;
            check_all($sformatf("rnd%0d", it), round_m, nr_m, int'(round_m > nr_m), int'(round_m == 2 * nr_m));
            check($sformatf("rnd%0d.pulses", it), pulses, exp_p);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
